text_mem_arbiter: RTL and testbench
===================================

# text_mem_arbiter

Single-port access controller for the 4 KiB text/attribute on-chip memory exported by `soc_system` (`onchip_mem_*`). It shares the one memory port between three requesters:
- the VGA character fetch pipeline, which has hard deadlines and is always granted;
- a built-in clear-screen fill engine;
- a host write/read port with a valid/ready handshake, used by the terminal/character writer.

It sits in the 25 MHz pixel domain, between the text renderer and the `soc_system` memory export, and tracks read-return latency so each read response goes back to the requester that issued it.

## Interface
Parameters:
- `ADDR_W`, 12, memory address width.
- `DATA_W`, 8, memory data width.
- `RD_LAT`, 1, memory read latency in cycles, from accepted read to valid `mem_readdata`. Legal values are 1 and 2.
- `CELLS`, 2400, number of cells written by a clear, at addresses 0..CELLS-1. Must be ≤ 2^ADDR_W.

Ports:
- `clk_clk`  in  1  — single clock, the 25 MHz pixel clock.
- `reset_reset_n`  in  1  — synchronous, active-low reset.
- `vga_req`  in  1  — VGA read request; served in the same cycle it is asserted.
- `vga_addr`  in  ADDR_W  — VGA read address.
- `vga_rdata`  out  DATA_W  — VGA read data.
- `vga_rvalid`  out  1  — `vga_rdata` valid; asserted RD_LAT cycles after `vga_req`.
- `host_valid`  in  1  — host request valid.
- `host_ready`  out  1  — host request accepted when `host_valid` and `host_ready` are both high.
- `host_write`  in  1  — 1 = write, 0 = read.
- `host_addr`  in  ADDR_W  — host address.
- `host_wdata`  in  DATA_W  — host write data.
- `host_rdata`  out  DATA_W  — host read data.
- `host_rvalid`  out  1  — `host_rdata` valid, one cycle.
- `clr_start`  in  1  — single-cycle pulse that starts a clear.
- `clr_char`  in  DATA_W  — fill value, latched when `clr_start` is accepted.
- `clr_busy`  out  1  — clear in progress.
- `mem_address`  out  ADDR_W  — connects to `onchip_mem_address`.
- `mem_chipselect`  out  1  — connects to `onchip_mem_chipselect`.
- `mem_clken`  out  1  — connects to `onchip_mem_clken`; constant 1.
- `mem_write`  out  1  — connects to `onchip_mem_write`.
- `mem_writedata`  out  DATA_W  — connects to `onchip_mem_writedata`.
- `mem_readdata`  in  DATA_W  — connects to `onchip_mem_readdata`.

## Operation
Arbitration uses fixed priority, evaluated every cycle: VGA first, then the clear engine, then the host.
- **VGA:** if `vga_req`=1, the port performs a read at `vga_addr`. Clear and host are both stalled that cycle.
- **Clear engine:** when idle, an accepted `clr_start` latches `clr_char`, zeroes the cell counter `clr_cnt`, and moves to BUSY.
- **Clear engine, BUSY:** each cycle with `vga_req`=0, the engine writes `clr_char` at address `clr_cnt`.
  - If `clr_cnt` = CELLS-1, the engine returns to IDLE.
  - Otherwise `clr_cnt` increments.
  - In cycles with `vga_req`=1, `clr_cnt` holds.
- **Clear restart:** `clr_start` while BUSY is ignored; no restart and no relatch.
- **Host:** `host_ready` = !`vga_req` & !`clr_busy`, combinational.
  - An accepted host request drives the port with `host_addr`, `host_wdata` and `host_write`.
  - No request is queued inside the block; the host holds its request until accepted.
- **Memory port signals:**
  - `mem_address`, `mem_write` and `mem_writedata` come combinationally from the granted source.
  - `mem_chipselect` is high in any cycle where a source is granted.
  - With no grant: `mem_chipselect`=0, `mem_write`=0, `mem_address`=0, `mem_writedata`=0.
- **Read return:** a tag pipeline of RD_LAT stages carries 2 bits per stage, {is_vga_read, is_host_read}.
  - When a tag reaches the last stage, the matching `*_rvalid` pulses for one cycle.
  - `vga_rdata` and `host_rdata` are both driven directly from `mem_readdata`.
  - Writes push an empty tag.
- **Reset** (`reset_reset_n`=0 at a clock edge):
  - Clear state → IDLE, `clr_cnt`=0, tag pipeline cleared.
  - While reset is held: `clr_busy`=0, `vga_rvalid`=0, `host_rvalid`=0, `host_ready`=0, and all `mem_*` outputs 0 except `mem_clken`=1.
  - A reset in the middle of a clear aborts it. Cells already written stay written.
  - A reset with reads in flight drops those responses; no `rvalid` is issued for them.

## Timing
- VGA read latency is exactly RD_LAT cycles, regardless of clear or host activity.
- Host read latency is RD_LAT cycles from acceptance.
- Host write completes in the acceptance cycle; no response is returned.
- `clr_busy` rises the cycle after `clr_start`. It falls the cycle after the write to CELLS-1.
- With no VGA traffic, a clear takes exactly CELLS cycles of writes, plus one cycle from start to first write. Each cycle with `vga_req`=1 during the clear adds one cycle.
- Simultaneous `clr_start` and an accepted host request in the same cycle: the host request is served, then the clear begins.
- Back-to-back requests are allowed every cycle from every source.

## Test plan
- **Reset values:** hold `reset_reset_n`=0 for 3 cycles with all inputs active. Required: all outputs at their reset values; `mem_chipselect`=0 and `mem_clken`=1.
- **VGA priority:** RD_LAT=1, `vga_req`=1 at address 0x010 while host writes 0xAA to 0x020 in the same cycle. Required: `host_ready`=0. One cycle later `vga_rvalid`=1 with the memory contents at 0x010. The host write is accepted in the following cycle.
- **Clear, no VGA traffic:** `clr_start` with `clr_char`=0x20. Required: `clr_busy` stays high for exactly 2400 cycles; addresses 0 through 2399 read back 0x20; address 2400 is unchanged.
- **Clear with VGA interleave:** during a clear, drive `vga_req` high every 4th cycle. Required: VGA data is returned correctly; the clear takes 2400 + number of VGA cycles; `host_ready` stays 0 throughout.
- **Host read/write round trip:** with RD_LAT=2, host writes 0x5C to 0x7FF, then reads 0x7FF. Required: `host_rvalid` asserts 2 cycles after the read is accepted, with `host_rdata`=0x5C. `vga_rvalid` stays 0.
- **Reset mid-operation:** assert reset 100 cycles into a clear, with one host read in flight. Required: no `host_rvalid`; `clr_busy`=0; cells 0–98 are filled, cells from 99 onward are unchanged.

Source files
------------

// File: rtl/text_mem_arbiter.sv
// Single-port arbiter for the text/attribute memory: VGA fetch > clear fill > host.
// Read responses are steered back to their requester through a tag pipeline that matches the memory latency.
module text_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CELLS  = 2400
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_char,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic {CLR_IDLE = 1'b0, CLR_BUSY = 1'b1} clr_state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CELLS - 1);

  clr_state_t        clr_state, clr_state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] clr_val;
  logic              clr_load;
  logic              vga_gnt, clr_gnt, host_gnt;
  logic [1:0]        tag_p [RD_LAT];

  // Every output is held quiet while reset is asserted, not just after the first edge.
  always_comb begin
    vga_gnt    = reset_reset_n & vga_req;
    clr_gnt    = reset_reset_n & ~vga_req & (clr_state == CLR_BUSY);
    host_ready = reset_reset_n & ~vga_req & (clr_state == CLR_IDLE);
    host_gnt   = host_ready & host_valid;
    clr_busy   = reset_reset_n & (clr_state == CLR_BUSY);
  end

  always_comb begin
    clr_state_nxt = clr_state;
    clr_cnt_nxt   = clr_cnt;
    clr_load      = 1'b0;
    case (clr_state)
      CLR_IDLE: begin
        if (clr_start) begin
          clr_state_nxt = CLR_BUSY;
          clr_cnt_nxt   = '0;
          clr_load      = 1'b1;
        end
      end
      CLR_BUSY: begin
        if (!vga_req) begin
          if (clr_cnt == CLR_LAST) clr_state_nxt = CLR_IDLE;
          else                     clr_cnt_nxt   = clr_cnt + ADDR_W'(1);
        end
      end
      default: clr_state_nxt = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      clr_state <= CLR_IDLE;
      clr_cnt   <= '0;
    end else begin
      clr_state <= clr_state_nxt;
      clr_cnt   <= clr_cnt_nxt;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (clr_load && reset_reset_n) clr_val <= clr_char;
  end

  always_comb begin
    mem_chipselect = vga_gnt | clr_gnt | host_gnt;
    mem_clken      = 1'b1;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_writedata  = '0;
    if (vga_gnt) begin
      mem_address = vga_addr;
    end else if (clr_gnt) begin
      mem_write     = 1'b1;
      mem_address   = clr_cnt;
      mem_writedata = clr_val;
    end else if (host_gnt) begin
      mem_write     = host_write;
      mem_address   = host_addr;
      mem_writedata = host_wdata;
    end
  end

  // Stage p0..p(RD_LAT-1): {is_vga_read, is_host_read} tags following the memory read latency
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < RD_LAT; i++) tag_p[i] <= 2'b00;
    end else begin
      tag_p[0] <= {vga_gnt, host_gnt & ~host_write};
      for (int i = 1; i < RD_LAT; i++) tag_p[i] <= tag_p[i-1];
    end
  end

  // Read-return stage: data comes straight from the memory, the tag says whose it is
  always_comb begin
    vga_rvalid  = reset_reset_n & tag_p[RD_LAT-1][1];
    host_rvalid = reset_reset_n & tag_p[RD_LAT-1][0];
    vga_rdata   = mem_readdata;
    host_rdata  = mem_readdata;
  end

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Bench for text_mem_arbiter: two instances (read latency 1 and 2) share stimulus, each with its own memory,
// and are compared every cycle against a cycle-level reference of the arbitration, clear and read-return rules.
module tb_text_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int CELLS = 2400;

  logic clk, rst_n;
  logic vga_req, host_valid, host_write, clr_start;
  logic [AW-1:0] vga_addr, host_addr;
  logic [DW-1:0] host_wdata, clr_char;
  logic [DW-1:0] rd_a, rd_b, rd_b1;

  logic [DW-1:0] vrd_a, hrd_a, wd_a, vrd_b, hrd_b, wd_b;
  logic vrv_a, hrv_a, rdy_a, busy_a, cs_a, ck_a, wr_a;
  logic vrv_b, hrv_b, rdy_b, busy_b, cs_b, ck_b, wr_b;
  logic [AW-1:0] addr_a, addr_b;

  logic [DW-1:0] mem_a [4096];
  logic [DW-1:0] mem_b [4096];
  logic [DW-1:0] refm  [4096];

  int errors = 0;
  int checks = 0;

  text_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .CELLS(CELLS)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vrd_a), .vga_rvalid(vrv_a),
    .host_valid(host_valid), .host_ready(rdy_a), .host_write(host_write), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(hrd_a), .host_rvalid(hrv_a),
    .clr_start(clr_start), .clr_char(clr_char), .clr_busy(busy_a),
    .mem_address(addr_a), .mem_chipselect(cs_a), .mem_clken(ck_a), .mem_write(wr_a),
    .mem_writedata(wd_a), .mem_readdata(rd_a));

  text_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .CELLS(CELLS)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vrd_b), .vga_rvalid(vrv_b),
    .host_valid(host_valid), .host_ready(rdy_b), .host_write(host_write), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(hrd_b), .host_rvalid(hrv_b),
    .clr_start(clr_start), .clr_char(clr_char), .clr_busy(busy_b),
    .mem_address(addr_b), .mem_chipselect(cs_b), .mem_clken(ck_b), .mem_write(wr_b),
    .mem_writedata(wd_b), .mem_readdata(rd_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pre(input int i);
    return DW'(i * 37 + 11);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference state: pending responses indexed by due cycle modulo 4, per latency (index 0 -> 1, 1 -> 2)
  logic          ev [2][4];
  logic [DW-1:0] ed [2][4];
  logic          eh [2][4];
  logic [DW-1:0] ehd[2][4];
  logic          m_busy, was_busy;
  int            m_idx, cyc, slot;
  logic [DW-1:0] m_val;
  logic          e_rdy, e_busy, e_cs, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic          evv[2], ehv[2];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_a[i] = pre(i); mem_b[i] = pre(i); refm[i] = pre(i);
    end
    for (int l = 0; l < 2; l++)
      for (int s = 0; s < 4; s++) begin
        ev[l][s] = 1'b0; eh[l][s] = 1'b0; ed[l][s] = '0; ehd[l][s] = '0;
      end
    m_busy = 1'b0; m_idx = 0; m_val = '0; cyc = 0;
    rd_a = '0; rd_b = '0; rd_b1 = '0;
    forever begin
      @(negedge clk);
      slot = cyc % 4;
      e_rdy = 1'b0; e_busy = 1'b0; e_cs = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
      if (rst_n) begin
        e_busy = m_busy;
        e_rdy  = !vga_req && !m_busy;
        if (vga_req) begin
          e_cs = 1'b1; e_addr = vga_addr;
        end else if (m_busy) begin
          e_cs = 1'b1; e_wr = 1'b1; e_addr = AW'(m_idx); e_wd = m_val;
        end else if (host_valid) begin
          e_cs = 1'b1; e_wr = host_write; e_addr = host_addr; e_wd = host_wdata;
        end
      end
      for (int l = 0; l < 2; l++) begin
        evv[l] = rst_n & ev[l][slot];
        ehv[l] = rst_n & eh[l][slot];
      end
      chk("outs_a", 32'({rdy_a, busy_a, cs_a, wr_a, ck_a, vrv_a, hrv_a, addr_a, wd_a}),
                    32'({e_rdy, e_busy, e_cs, e_wr, 1'b1, evv[0], ehv[0], e_addr, e_wd}));
      chk("outs_b", 32'({rdy_b, busy_b, cs_b, wr_b, ck_b, vrv_b, hrv_b, addr_b, wd_b}),
                    32'({e_rdy, e_busy, e_cs, e_wr, 1'b1, evv[1], ehv[1], e_addr, e_wd}));
      if (evv[0]) chk("vga_rdata_a", 32'(vrd_a), 32'(ed[0][slot]));
      if (evv[1]) chk("vga_rdata_b", 32'(vrd_b), 32'(ed[1][slot]));
      if (ehv[0]) chk("host_rdata_a", 32'(hrd_a), 32'(ehd[0][slot]));
      if (ehv[1]) chk("host_rdata_b", 32'(hrd_b), 32'(ehd[1][slot]));

      // Bench memories follow whatever each DUT actually drives
      rd_b = rd_b1;
      if (cs_b && !wr_b) rd_b1 = mem_b[addr_b];
      if (cs_b && wr_b)  mem_b[addr_b] = wd_b;
      if (cs_a && !wr_a) rd_a = mem_a[addr_a];
      if (cs_a && wr_a)  mem_a[addr_a] = wd_a;

      for (int l = 0; l < 2; l++) begin ev[l][slot] = 1'b0; eh[l][slot] = 1'b0; end
      if (!rst_n) begin
        for (int l = 0; l < 2; l++)
          for (int s = 0; s < 4; s++) begin ev[l][s] = 1'b0; eh[l][s] = 1'b0; end
        m_busy = 1'b0; m_idx = 0;
      end else begin
        was_busy = m_busy;
        if (vga_req) begin
          for (int l = 0; l < 2; l++) begin
            ev[l][(cyc + l + 1) % 4] = 1'b1; ed[l][(cyc + l + 1) % 4] = refm[vga_addr];
          end
        end else if (was_busy) begin
          refm[m_idx] = m_val;
          if (m_idx == CELLS - 1) m_busy = 1'b0;
          else m_idx++;
        end else if (host_valid) begin
          if (host_write) refm[host_addr] = host_wdata;
          else
            for (int l = 0; l < 2; l++) begin
              eh[l][(cyc + l + 1) % 4] = 1'b1; ehd[l][(cyc + l + 1) % 4] = refm[host_addr];
            end
        end
        if (!was_busy && clr_start) begin m_busy = 1'b1; m_idx = 0; m_val = clr_char; end
      end
      cyc++;
    end
  end

  task automatic idle_in();
    vga_req = 1'b0; host_valid = 1'b0; host_write = 1'b0; clr_start = 1'b0;
    vga_addr = '0; host_addr = '0; host_wdata = '0; clr_char = '0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  int n, nv, hr, t;

  initial begin
    rst_n = 1'b0;
    vga_req = 1'b1; host_valid = 1'b1; host_write = 1'b1; clr_start = 1'b1;
    vga_addr = 12'h155; host_addr = 12'h2AA; host_wdata = 8'h99; clr_char = 8'h41;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", 32'(cs_a), 32'd0);
    chk("rst_clken", 32'(ck_a), 32'd1);
    chk("rst_ready", 32'(rdy_b), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    nxt(); rst_n = 1'b1; idle_in();

    // VGA beats a simultaneous host write
    nxt();
    vga_req = 1'b1; vga_addr = 12'h010;
    host_valid = 1'b1; host_write = 1'b1; host_addr = 12'h020; host_wdata = 8'hAA;
    @(negedge clk);
    chk("prio_ready_a", 32'(rdy_a), 32'd0);
    nxt(); vga_req = 1'b0;
    @(negedge clk);
    chk("prio_vrv_a", 32'(vrv_a), 32'd1);
    chk("prio_vrd_a", 32'(vrd_a), 32'h5B);
    chk("prio_accept", 32'({rdy_a, wr_a, addr_a}), 32'({1'b1, 1'b1, 12'h020}));
    nxt(); host_valid = 1'b0;
    @(negedge clk);
    chk("prio_vrd_b", 32'({vrv_b, vrd_b}), 32'({1'b1, 8'h5B}));
    chk("prio_mem", 32'(mem_a[32]), 32'hAA);

    // Clear with no VGA traffic
    nxt(); clr_start = 1'b1; clr_char = 8'h20;
    nxt(); clr_start = 1'b0;
    n = 0; t = 0;
    while (t < 4000) begin
      @(negedge clk); t++;
      if (busy_a) n++;
      else if (n > 0) break;
    end
    chk("clr_len", 32'(n), 32'd2400);
    chk("clr_first", 32'(mem_a[0]), 32'h20);
    chk("clr_last", 32'(mem_b[2399]), 32'h20);
    chk("clr_beyond", 32'(mem_a[2400]), 32'hEB);

    // Clear interleaved with VGA reads every 4th cycle; restarts mid-clear must be ignored
    nxt(); clr_start = 1'b1; clr_char = 8'h2E;
    nxt(); clr_start = 1'b0;
    n = 0; nv = 0; hr = 0; t = 0;
    while (t < 4000) begin
      vga_req = (t % 4 == 3); vga_addr = AW'($urandom);
      host_valid = 1'($urandom); host_write = 1'($urandom);
      host_addr = AW'($urandom); host_wdata = DW'($urandom);
      clr_start = (t < 2000) && ($urandom_range(0, 15) == 0); clr_char = DW'($urandom);
      @(negedge clk);
      if (busy_a) begin
        n++;
        if (vga_req) nv++;
        if (rdy_a) hr++;
      end else if (n > 0) break;
      nxt(); t++;
    end
    nxt(); idle_in();
    chk("clr_vga_len", 32'(n), 32'(2400 + nv));
    chk("clr_vga_ready", 32'(hr), 32'd0);
    chk("clr_norelatch", 32'(mem_a[1000]), 32'h2E);

    // Host write/read round trip
    nxt(); host_valid = 1'b1; host_write = 1'b1; host_addr = 12'h7FF; host_wdata = 8'h5C;
    @(negedge clk); chk("rt_wr_ready", 32'(rdy_b), 32'd1);
    nxt(); host_write = 1'b0;
    @(negedge clk); chk("rt_rd_ready", 32'(rdy_b), 32'd1);
    nxt(); idle_in();
    @(negedge clk); chk("rt_early_b", 32'(hrv_b), 32'd0);
    nxt();
    @(negedge clk);
    chk("rt_hrv_b", 32'({hrv_b, hrd_b}), 32'({1'b1, 8'h5C}));
    chk("rt_vrv_b", 32'(vrv_b), 32'd0);

    // Reset 100 cycles into a clear
    nxt(); clr_start = 1'b1; clr_char = 8'h77;
    nxt(); clr_start = 1'b0;
    repeat (98) nxt();
    nxt(); rst_n = 1'b0;
    @(negedge clk); chk("mid_rst_busy", 32'(busy_a), 32'd0);
    nxt(); rst_n = 1'b1;
    @(negedge clk);
    chk("mid_abort", 32'({busy_a, busy_b}), 32'd0);
    chk("mid_cell98", 32'(mem_a[98]), 32'h77);
    chk("mid_cell99", 32'(mem_b[99]), 32'h2E);

    // Host read dropped by a reset while in flight
    nxt(); host_valid = 1'b1; host_write = 1'b0; host_addr = 12'h123;
    @(negedge clk); chk("drop_accept", 32'(rdy_a), 32'd1);
    nxt(); host_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk); chk("drop_rst", 32'({hrv_a, hrv_b}), 32'd0);
    nxt(); rst_n = 1'b1;
    @(negedge clk); chk("drop_b", 32'(hrv_b), 32'd0);

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      nxt();
      rst_n = ($urandom_range(0, 599) != 0);
      vga_req = ($urandom_range(0, 99) < 30); vga_addr = AW'($urandom);
      host_valid = 1'($urandom); host_write = 1'($urandom);
      host_addr = AW'($urandom); host_wdata = DW'($urandom);
      clr_start = ($urandom_range(0, 999) == 0); clr_char = DW'($urandom);
    end
    nxt(); idle_in(); rst_n = 1'b1;
    repeat (4) nxt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
